trace_capture_ctrl: RTL

TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

---
 rtl/scope_pkg.sv | 31 +++
 rtl/trace_capture_ctrl_if.sv | 14 +
 rtl/trig_detect.sv | 39 +++
 rtl/trace_capture_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared constants, state encoding and pixel-address helper for the trace capture controller.
package scope_pkg;

  localparam int unsigned H_PIX      = 800;
  localparam int unsigned V_PIX      = 480;
  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned FULL_IMAGE = H_PIX * V_PIX;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ARM     = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_e;

  function automatic int unsigned full_image(input int unsigned h_pix, input int unsigned v_pix);
    return h_pix * v_pix;
  endfunction

  // Higher sample codes map to lower rows; mid-scale lands just above the centre line.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0]        smp,
                                                 input logic [ADDR_W-1:0] col,
                                                 input int unsigned       h_pix,
                                                 input int unsigned       v_pix);
    logic [ADDR_W-1:0] row;
    row = ADDR_W'(v_pix / 2 + 32'd127) - {{(ADDR_W-8){1'b0}}, smp};
    return row * ADDR_W'(h_pix) + col;
  endfunction

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// Sample-in / frame-RAM-write-out bundle of the trace capture controller.
interface trace_capture_ctrl_if;
  import scope_pkg::*;

  logic [11:0]       adc_data;
  logic              adc_valid;
  logic [ADDR_W-1:0] wraddress;
  logic              data;
  logic              wren;

  modport master (input adc_data, adc_valid, output wraddress, data, wren);
  modport slave  (output adc_data, adc_valid, input wraddress, data, wren);

endinterface

// File: rtl/trig_detect.sv
// Rising-crossing detector: keeps the previous accepted sample and flags prev < level <= cur.
module trig_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       smp_en,
  input  logic [7:0] smp,
  input  logic [7:0] level,
  output logic       trig
);

  logic [7:0] prev_q, prev_d;
  logic       have_q, have_d;

  // No crossing can be reported until one sample has seeded the history.
  assign trig = smp_en && have_q && (prev_q < level) && (smp >= level);

  always_comb begin
    prev_d = prev_q;
    have_d = have_q;
    if (clr) begin
      have_d = 1'b0;
    end else if (smp_en) begin
      prev_d = smp;
      have_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 8'd0;
      have_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      have_q <= have_d;
    end
  end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Oscilloscope trace capture: clears the frame RAM, waits for a trigger, then plots one column per
// accepted sample. Define AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT cycles in ARM.
//   state   | meaning
//   IDLE    | waiting for run or single
//   CLEAR   | writing background to every pixel
//   ARM     | decimating samples, looking for a rising crossing
//   CAPTURE | plotting columns 1..H_PIX-1
//   HOLD    | frame complete, waiting for display end-of-frame
module trace_capture_ctrl
  import scope_pkg::*;
#(
  parameter int unsigned H_PIX        = scope_pkg::H_PIX,
  parameter int unsigned V_PIX        = scope_pkg::V_PIX,
  parameter logic [23:0] AUTO_TIMEOUT = 24'd5_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  trace_capture_ctrl_if.master        bus,
  input  logic [7:0]                  trig_level,
  input  logic [7:0]                  decim,
  input  logic                        run,
  input  logic                        single,
  input  logic                        frame_done,
  output logic                        busy,
  output logic [2:0]                  state_o
);

  localparam int unsigned       FULL_PIX  = full_image(H_PIX, V_PIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FULL_PIX - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(H_PIX - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [7:0]        decim_q, decim_d;
  logic [ADDR_W-1:0] wraddress_q, wraddress_d;
  logic              data_q, data_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;

  logic              in_acq;
  logic              accept;
  logic              arm_entry;
  logic              trig;
  logic              timeout;
  logic [7:0]        smp;

  assign smp       = bus.adc_data[11:4];
  assign in_acq    = (state_q == ARM) || (state_q == CAPTURE);
  assign accept    = in_acq && bus.adc_valid && (dcnt_q == decim_q);
  assign arm_entry = (state_q == CLEAR) && (clr_addr_q == LAST_ADDR);

  trig_detect u_trig (
    .clk    (clk),
    .rst    (rst),
    .clr    (arm_entry),
    .smp_en (accept && (state_q == ARM)),
    .smp    (smp),
    .level  (trig_level),
    .trig   (trig)
  );

`ifdef AUTO_TRIG_EN
  logic [23:0] timer_q, timer_d;

  // Reloaded on every ARM entry, so a timeout never leaks into the next acquisition.
  always_comb begin
    timer_d = timer_q;
    if (arm_entry) begin
      timer_d = AUTO_TIMEOUT;
    end else if ((state_q == ARM) && (timer_q != 24'd0)) begin
      timer_d = timer_q - 24'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= 24'd0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timeout = (state_q == ARM) && (timer_q == 24'd0);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = '0;
    col_d       = col_q;
    dcnt_d      = dcnt_q;
    decim_d     = decim_q;
    wraddress_d = wraddress_q;
    data_d      = data_q;
    wren_d      = 1'b0;

    if (in_acq && bus.adc_valid) begin
      dcnt_d = accept ? 8'd0 : dcnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (run || single) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_addr_d  = clr_addr_q + ADDR_W'(1);
        wraddress_d = clr_addr_q;
        data_d      = 1'b0;
        wren_d      = 1'b1;
        if (arm_entry) begin
          state_d = ARM;
          decim_d = decim;
          dcnt_d  = 8'd0;
          col_d   = '0;
        end
      end
      ARM: begin
        if (accept && (trig || timeout)) begin
          wraddress_d = pix_addr(smp, '0, H_PIX, V_PIX);
          data_d      = 1'b1;
          wren_d      = 1'b1;
          col_d       = ADDR_W'(1);
          state_d     = (H_PIX == 1) ? HOLD : CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          wraddress_d = pix_addr(smp, col_q, H_PIX, V_PIX);
          data_d      = 1'b1;
          wren_d      = 1'b1;
          if (col_q == LAST_COL) begin
            state_d = HOLD;
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
        end
      end
      HOLD: begin
        if (frame_done) begin
          state_d = run ? CLEAR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_addr_q  <= '0;
      col_q       <= '0;
      dcnt_q      <= 8'd0;
      decim_q     <= 8'd0;
      wraddress_q <= '0;
      data_q      <= 1'b0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      col_q       <= col_d;
      dcnt_q      <= dcnt_d;
      decim_q     <= decim_d;
      wraddress_q <= wraddress_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.wraddress = wraddress_q;
  assign bus.data      = data_q;
  assign bus.wren      = wren_q;
  assign busy          = busy_q;
  assign state_o       = state_q;

endmodule
